// File: rtl/addr_stack_if.sv
// Command, staging and observation signals of the addr_stack return-address stack.
// The master drives commands and staging bytes; the slave (the stack) drives state.
interface addr_stack_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 8,
  parameter int BYTE_WIDTH = 8
);
  localparam int SPW = $clog2(DEPTH);

  logic [2:0]            cmd;
  logic [BYTE_WIDTH-1:0] data_in;
  logic                  lo_we;
  logic                  hi_we;
  logic [2:0]            vec;
  logic                  clr_err;
  logic                  byte_sel;
  logic [ADDR_WIDTH-1:0] pc;
  logic [BYTE_WIDTH-1:0] data_out;
  logic [SPW-1:0]        sp;
  logic [SPW-1:0]        level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output cmd, data_in, lo_we, hi_we, vec, clr_err, byte_sel,
    input  pc, data_out, sp, level, overflow, underflow
  );

  modport slave (
    input  cmd, data_in, lo_we, hi_we, vec, clr_err, byte_sel,
    output pc, data_out, sp, level, overflow, underflow
  );
endinterface

// File: rtl/addr_stack.sv
// 8008-style program-counter / return-address stack: top entry is the live pc,
// CALL/RSTV push, RET pops, with a byte-staged jump/call target.
module addr_stack #(
  parameter int ADDR_WIDTH = 14,
  parameter int DEPTH      = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int OVF_MODE   = 0
) (
  input logic        clk,
  input logic        rst_n,
  addr_stack_if.slave bus
);
  localparam int SPW = $clog2(DEPTH);
  localparam int HW  = ADDR_WIDTH - BYTE_WIDTH;
  localparam logic [SPW-1:0] TOP = SPW'(DEPTH - 1);

  localparam logic [2:0] CMD_INC  = 3'd1;
  localparam logic [2:0] CMD_JMP  = 3'd2;
  localparam logic [2:0] CMD_CALL = 3'd3;
  localparam logic [2:0] CMD_RET  = 3'd4;
  localparam logic [2:0] CMD_RSTV = 3'd5;

  logic [DEPTH-1:0][ADDR_WIDTH-1:0] stk;
  logic [ADDR_WIDTH-1:0]            tgt, push_val, pc;
  logic [SPW-1:0]                   sp, level, sp_inc, sp_dec;
  logic                             ovf, unf;
  logic                             is_push, is_pop, ovf_hit, unf_hit;

  assign pc       = stk[sp];
  assign sp_inc   = sp + SPW'(1);
  assign sp_dec   = sp - SPW'(1);
  assign is_push  = (bus.cmd == CMD_CALL) || (bus.cmd == CMD_RSTV);
  assign is_pop   = (bus.cmd == CMD_RET);
  assign ovf_hit  = is_push && (level == TOP);
  assign unf_hit  = is_pop && (level == '0);
  assign push_val = (bus.cmd == CMD_CALL) ? tgt : ADDR_WIDTH'({bus.vec, 3'b000});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stk   <= '0;
      tgt   <= '0;
      sp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      // Staging lands after the edge, so a same-cycle JMP/CALL sees the old target.
      if (bus.lo_we) tgt[BYTE_WIDTH-1:0] <= bus.data_in;
      if (bus.hi_we) tgt[ADDR_WIDTH-1:BYTE_WIDTH] <= bus.data_in[HW-1:0];
      ovf <= ovf_hit | (ovf & ~bus.clr_err);
      unf <= unf_hit | (unf & ~bus.clr_err);
      case (bus.cmd)
        CMD_INC: stk[sp] <= stk[sp] + ADDR_WIDTH'(1);
        CMD_JMP: stk[sp] <= tgt;
        CMD_CALL, CMD_RSTV: begin
          // In wrap mode a full stack still pushes, clobbering the oldest entry.
          if (!ovf_hit || OVF_MODE == 0) begin
            sp          <= sp_inc;
            stk[sp_inc] <= push_val;
            if (!ovf_hit) level <= level + SPW'(1);
          end
        end
        CMD_RET: begin
          if (!unf_hit || OVF_MODE == 0) begin
            sp <= sp_dec;
            if (!unf_hit) level <= level - SPW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.byte_sel) bus.data_out[HW-1:0] = pc[ADDR_WIDTH-1:BYTE_WIDTH];
    else              bus.data_out = pc[BYTE_WIDTH-1:0];
  end

  assign bus.pc        = pc;
  assign bus.sp        = sp;
  assign bus.level     = level;
  assign bus.overflow  = ovf;
  assign bus.underflow = unf;
endmodule

// File: tb/tb_addr_stack.sv
// Bench for addr_stack: wrap-mode and trap-mode instances share stimulus and are
// checked against hand vectors and an array-based reference stack.
module tb_addr_stack;
  localparam int AW = 14, D = 8, BW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addr_stack_if #(.ADDR_WIDTH(AW), .DEPTH(D), .BYTE_WIDTH(BW)) b0 ();
  addr_stack_if #(.ADDR_WIDTH(AW), .DEPTH(D), .BYTE_WIDTH(BW)) b1 ();

  addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .BYTE_WIDTH(BW), .OVF_MODE(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  addr_stack #(.ADDR_WIDTH(AW), .DEPTH(D), .BYTE_WIDTH(BW), .OVF_MODE(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  int checks = 0, errors = 0;

  // reference state, index 0 = wrap mode, 1 = trap mode
  int m_stk [2][D];
  int m_sp [2], m_lvl [2], m_ovf [2], m_unf [2];
  int m_tgt;

  logic [2:0] s_cmd, s_vec;
  logic [7:0] s_d;
  logic s_lo, s_hi, s_clr, s_bs;

  typedef struct {
    logic r; logic [2:0] c; logic [7:0] d; logic lo, hi; logic [2:0] v; logic clr, bs;
    logic [13:0] pc; logic [2:0] sp, lvl; logic ovf, unf; logic [7:0] dout;
  } vec_t;
  vec_t tbl [25];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    int v;
    if (!rst_n) begin
      m_tgt = 0;
      for (int m = 0; m < 2; m++) begin
        for (int e = 0; e < D; e++) m_stk[m][e] = 0;
        m_sp[m] = 0; m_lvl[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
      end
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (s_clr) begin m_ovf[m] = 0; m_unf[m] = 0; end
      case (s_cmd)
        3'd1: m_stk[m][m_sp[m]] = (m_stk[m][m_sp[m]] + 1) % (1 << AW);
        3'd2: m_stk[m][m_sp[m]] = m_tgt;
        3'd3, 3'd5: begin
          v = (s_cmd == 3'd3) ? m_tgt : int'(s_vec) * 8;
          if (m_lvl[m] == D - 1) begin
            m_ovf[m] = 1;
            if (m == 0) begin m_sp[m] = (m_sp[m] + 1) % D; m_stk[m][m_sp[m]] = v; end
          end else begin
            m_sp[m] = (m_sp[m] + 1) % D; m_stk[m][m_sp[m]] = v; m_lvl[m]++;
          end
        end
        3'd4: begin
          if (m_lvl[m] == 0) begin
            m_unf[m] = 1;
            if (m == 0) m_sp[m] = (m_sp[m] + D - 1) % D;
          end else begin
            m_sp[m] = (m_sp[m] + D - 1) % D; m_lvl[m]--;
          end
        end
        default: ;
      endcase
    end
    if (s_lo) m_tgt = (m_tgt & 16'hFF00) | int'(s_d);
    if (s_hi) m_tgt = (m_tgt & 16'h00FF) | ((int'(s_d) % (1 << (AW - BW))) << 8);
  endtask

  task automatic cmp_model();
    int pc0, pc1;
    pc0 = m_stk[0][m_sp[0]];
    pc1 = m_stk[1][m_sp[1]];
    chk("m0_pc", 32'(b0.pc), pc0);
    chk("m0_sp", 32'(b0.sp), m_sp[0]);
    chk("m0_level", 32'(b0.level), m_lvl[0]);
    chk("m0_ovf", 32'(b0.overflow), m_ovf[0]);
    chk("m0_unf", 32'(b0.underflow), m_unf[0]);
    chk("m0_dout", 32'(b0.data_out), s_bs ? (pc0 >> 8) : (pc0 & 255));
    chk("m1_pc", 32'(b1.pc), pc1);
    chk("m1_sp", 32'(b1.sp), m_sp[1]);
    chk("m1_level", 32'(b1.level), m_lvl[1]);
    chk("m1_ovf", 32'(b1.overflow), m_ovf[1]);
    chk("m1_unf", 32'(b1.underflow), m_unf[1]);
    chk("m1_dout", 32'(b1.data_out), s_bs ? (pc1 >> 8) : (pc1 & 255));
  endtask

  task automatic step(input logic r, input logic [2:0] c, input logic [7:0] d,
                      input logic lo, input logic hi, input logic [2:0] v,
                      input logic clr, input logic bs);
    @(negedge clk);
    rst_n = r; s_cmd = c; s_d = d; s_lo = lo; s_hi = hi; s_vec = v; s_clr = clr; s_bs = bs;
    b0.cmd = c; b0.data_in = d; b0.lo_we = lo; b0.hi_we = hi; b0.vec = v; b0.clr_err = clr; b0.byte_sel = bs;
    b1.cmd = c; b1.data_in = d; b1.lo_we = lo; b1.hi_we = hi; b1.vec = v; b1.clr_err = clr; b1.byte_sel = bs;
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  initial begin
    //          r  c     d      lo hi v  clr bs  pc        sp lvl ovf unf dout
    tbl[0]  = '{0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[1]  = '{1, 3'd1, 8'h00, 0, 0, 0, 0, 0, 14'h0001, 0, 0, 0, 0, 8'h01};
    tbl[2]  = '{1, 3'd1, 8'h00, 0, 0, 0, 0, 0, 14'h0002, 0, 0, 0, 0, 8'h02};
    tbl[3]  = '{1, 3'd1, 8'h00, 0, 0, 0, 0, 0, 14'h0003, 0, 0, 0, 0, 8'h03};
    tbl[4]  = '{1, 3'd0, 8'h34, 1, 0, 0, 0, 0, 14'h0003, 0, 0, 0, 0, 8'h03};
    tbl[5]  = '{1, 3'd0, 8'h12, 0, 1, 0, 0, 0, 14'h0003, 0, 0, 0, 0, 8'h03};
    tbl[6]  = '{1, 3'd3, 8'h00, 0, 0, 0, 0, 0, 14'h1234, 1, 1, 0, 0, 8'h34};
    tbl[7]  = '{1, 3'd4, 8'h00, 0, 0, 0, 0, 0, 14'h0003, 0, 0, 0, 0, 8'h03};
    tbl[8]  = '{1, 3'd2, 8'h00, 0, 0, 0, 0, 0, 14'h1234, 0, 0, 0, 0, 8'h34};
    tbl[9]  = '{1, 3'd0, 8'h00, 0, 0, 0, 0, 1, 14'h1234, 0, 0, 0, 0, 8'h12};
    tbl[10] = '{1, 3'd0, 8'h00, 0, 0, 0, 0, 0, 14'h1234, 0, 0, 0, 0, 8'h34};
    tbl[11] = '{1, 3'd0, 8'hFF, 1, 1, 0, 0, 0, 14'h1234, 0, 0, 0, 0, 8'h34};
    tbl[12] = '{1, 3'd2, 8'h00, 0, 0, 0, 0, 0, 14'h3FFF, 0, 0, 0, 0, 8'hFF};
    tbl[13] = '{1, 3'd1, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[14] = '{1, 3'd3, 8'h55, 1, 0, 0, 0, 0, 14'h3FFF, 1, 1, 0, 0, 8'hFF};
    tbl[15] = '{1, 3'd2, 8'h00, 0, 0, 0, 0, 0, 14'h3F55, 1, 1, 0, 0, 8'h55};
    tbl[16] = '{1, 3'd6, 8'h00, 0, 0, 0, 0, 0, 14'h3F55, 1, 1, 0, 0, 8'h55};
    tbl[17] = '{1, 3'd7, 8'h00, 0, 0, 0, 0, 1, 14'h3F55, 1, 1, 0, 0, 8'h3F};
    tbl[18] = '{0, 3'd3, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[19] = '{1, 3'd0, 8'h77, 1, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[20] = '{0, 3'd0, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[21] = '{1, 3'd2, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 0, 0, 0, 0, 8'h00};
    tbl[22] = '{1, 3'd4, 8'h00, 0, 0, 0, 0, 0, 14'h0000, 7, 0, 0, 1, 8'h00};
    tbl[23] = '{1, 3'd4, 8'h00, 0, 0, 0, 1, 0, 14'h0000, 6, 0, 0, 1, 8'h00};
    tbl[24] = '{1, 3'd0, 8'h00, 0, 0, 0, 1, 0, 14'h0000, 6, 0, 0, 0, 8'h00};

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].d, tbl[i].lo, tbl[i].hi, tbl[i].v, tbl[i].clr, tbl[i].bs);
      chk($sformatf("t%0d_pc", i), 32'(b0.pc), 32'(tbl[i].pc));
      chk($sformatf("t%0d_sp", i), 32'(b0.sp), 32'(tbl[i].sp));
      chk($sformatf("t%0d_level", i), 32'(b0.level), 32'(tbl[i].lvl));
      chk($sformatf("t%0d_ovf", i), 32'(b0.overflow), 32'(tbl[i].ovf));
      chk($sformatf("t%0d_unf", i), 32'(b0.underflow), 32'(tbl[i].unf));
      chk($sformatf("t%0d_dout", i), 32'(b0.data_out), 32'(tbl[i].dout));
    end

    // overflow on the eighth nested RSTV, both modes
    step(0, 3'd0, 8'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 3'd5, 8'h00, 0, 0, 3'd5, 0, 0);
    chk("pre_ovf_level", 32'(b0.level), 7);
    chk("pre_ovf_flag", 32'(b0.overflow), 0);
    step(1, 3'd5, 8'h00, 0, 0, 3'd5, 0, 0);
    chk("ovf0_flag", 32'(b0.overflow), 1);
    chk("ovf0_pc", 32'(b0.pc), 32'h28);
    chk("ovf0_level", 32'(b0.level), 7);
    chk("ovf0_sp", 32'(b0.sp), 0);
    chk("ovf1_flag", 32'(b1.overflow), 1);
    chk("ovf1_sp", 32'(b1.sp), 7);
    chk("ovf1_pc", 32'(b1.pc), 32'h28);
    chk("ovf1_level", 32'(b1.level), 7);
    step(1, 3'd3, 8'h00, 0, 0, 3'd0, 1, 0);
    chk("ovf_clr_race", 32'(b1.overflow), 1);
    step(1, 3'd0, 8'h00, 0, 0, 3'd0, 1, 0);
    chk("ovf_clr", 32'(b1.overflow), 0);

    // randomized traffic against the reference stack
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) != 0), 3'($urandom_range(7)), 8'($urandom),
           1'($urandom), 1'($urandom), 3'($urandom), ($urandom_range(7) == 0), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/addr_stack.md
ADDR_STACK -- requirements
Module: addr_stack

Interface
REQ-001 Parameter ADDR_WIDTH, default 14, SHALL set program-address width (9..16).
REQ-002 Parameter DEPTH, default 8, SHALL set number of address levels (power of 2, >=2); SPW = $clog2(DEPTH).
REQ-003 Parameter BYTE_WIDTH, default 8, SHALL set data-bus byte width.
REQ-004 Parameter OVF_MODE, default 0, SHALL select 0 = wrap (8008-compatible), 1 = trap (illegal op suppressed).
REQ-005 Port clk  input  1  rising-edge clock; one clock domain.
REQ-006 Port rst_n  input  1  reset, synchronous, active-low.
REQ-007 Port cmd  input  3  command: 0 NOP, 1 INC, 2 JMP, 3 CALL, 4 RET, 5 RSTV; 6,7 treated as NOP.
REQ-008 Port data_in  input  BYTE_WIDTH  byte for target staging.
REQ-009 Port lo_we  input  1  write data_in into target low byte.
REQ-010 Port hi_we  input  1  write data_in[ADDR_WIDTH-BYTE_WIDTH-1:0] into target high part.
REQ-011 Port vec  input  3  restart vector for RSTV.
REQ-012 Port clr_err  input  1  clear sticky error flags.
REQ-013 Port byte_sel  input  1  0 = low byte, 1 = high part of pc on data_out.
REQ-014 Port pc  output  ADDR_WIDTH  current top-of-stack entry (program counter).
REQ-015 Port data_out  output  BYTE_WIDTH  combinational byte of pc per byte_sel; high part zero-extended.
REQ-016 Port sp  output  SPW  stack pointer selecting the pc entry.
REQ-017 Port level  output  SPW  nesting depth, 0..DEPTH-1.
REQ-018 Port overflow  output  1  sticky: CALL/RSTV attempted at level DEPTH-1.
REQ-019 Port underflow  output  1  sticky: RET attempted at level 0.

Function
REQ-020 Storage SHALL be DEPTH entries of ADDR_WIDTH bits; pc SHALL equal entry[sp].
REQ-021 Exactly one cmd SHALL execute per cycle; all updates registered, visible the cycle after.
REQ-022 Staging writes SHALL occur in parallel with cmd; JMP/CALL SHALL use the target value registered before the edge (no same-cycle bypass).
REQ-023 INC: entry[sp] <= entry[sp]+1 modulo 2^ADDR_WIDTH (0x3FFF -> 0x0000 at default).
REQ-024 JMP: entry[sp] <= target; sp, level unchanged.
REQ-025 CALL: sp <= sp+1 mod DEPTH; entry[sp+1] <= target; level <= level+1; old entry keeps return address (caller has already incremented it).
REQ-026 RSTV: as CALL with target = {vec, 3'b000} zero-extended to ADDR_WIDTH; staged target unchanged.
REQ-027 RET: sp <= sp-1 mod DEPTH; level <= level-1; entries unchanged.
REQ-028 CALL/RSTV at level DEPTH-1: overflow <= 1; mode 0 SHALL perform the push (overwrites oldest entry) with level held at DEPTH-1; mode 1 SHALL leave sp, level, entries unchanged.
REQ-029 RET at level 0: underflow <= 1; mode 0 SHALL decrement sp (wraps) with level held at 0; mode 1 SHALL leave state unchanged.
REQ-030 clr_err SHALL clear both flags; a new error in the same cycle SHALL win (flag set).
REQ-031 lo_we and hi_we together SHALL write both parts in one cycle.
REQ-032 Undefined cmd codes SHALL change no state and set no flag.

Reset
REQ-033 rst_n low at a rising edge SHALL set all entries, target, sp, level to 0 and clear overflow, underflow; it overrides any cmd or staging write that cycle.
REQ-034 Reset mid-sequence (e.g. after lo_we only) SHALL discard the partial target.

Verification
REQ-035 Reset, then INC x3 -> pc=0x0003, sp=0, level=0, flags 0.
REQ-036 Stage lo=0x34, hi=0x12 (separate cycles), CALL -> pc=0x1234, sp=1, level=1; RET -> pc=0x0003, sp=0.
REQ-037 pc=0x3FFF, INC -> pc=0x0000, no flag; byte_sel=1 with pc=0x1234 -> data_out=0x12.
REQ-038 Mode 0: eight RSTV vec=5 calls from level 0 -> 8th sets overflow, pc=0x0028, level=7; mode 1: 8th leaves sp=7, pc unchanged.
REQ-039 RET at level 0 -> underflow=1; clr_err with simultaneous failing RET -> underflow stays 1; clr_err alone -> 0.
REQ-040 lo_we with CALL same cycle -> CALL uses old target; rst_n low with CALL -> all outputs 0 next cycle.
